// File: rtl/alu_pkg.sv
// Shared ALU definitions: arbiter state encoding and the fixed datapath width
// of the shared adder.
package alu_pkg;

   localparam int ADDER_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } arb_state_t;

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Round-robin picker: finds the first valid requester at or after rr_ptr,
// wrapping around, and returns it as a one-hot grant plus an index.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    winner,
   output logic               found
);

   int idx;

   // NOTE: every output gets a default before the loop so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      // Scan farthest-first so the last hit is the closest to rr_ptr.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
      if (found) grant[winner] = 1'b1;
   end

endmodule

// File: rtl/sixty_four_bit_adder.sv
// 64-bit ripple-carry adder shared by the ALU issue slots.
// Purely combinational: sum/c_out settle one ripple chain after a/b/c_in.
module sixty_four_bit_adder (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        c_in,
   output logic [63:0] sum,
   output logic        c_out
);

   logic carry;

   // NOTE: blocking '=' here is deliberate; carry is a combinational temporary
   // that must update within one pass of the loop. Clocked state uses '<='.
   always_comb begin
      carry = c_in;
      sum   = '0;
      for (int i = 0; i < 64; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 64-bit adder among NUM_REQ requesters with round-robin grant and
// valid/ready handshakes; operands and results are registered around the adder.
module adder_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = ADDER_WIDTH,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_cin,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [WIDTH-1:0]         resp_sum,
   output logic                     resp_cout,
   output logic                     busy
);

   arb_state_t         state;
   arb_state_t         state_nxt;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    id_r;
   logic [NUM_REQ-1:0] grant;
   logic               found;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               op_cin;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .winner    (winner),
      .found     (found)
   );

   sixty_four_bit_adder u_adder (
      .a     (op_a),
      .b     (op_b),
      .c_in  (op_cin),
      .sum   (add_sum),
      .c_out (add_cout)
   );

   assign req_ready = (state == IDLE) ? grant : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = CALC;
         CALC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the operand and result registers are reset even though they are
   // plain datapath, because their post-reset contents are visible on resp_*.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_cin     <= 1'b0;
         id_r       <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_sum   <= '0;
         resp_cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  op_a   <= req_a[winner*WIDTH +: WIDTH];
                  op_b   <= req_b[winner*WIDTH +: WIDTH];
                  op_cin <= req_cin[winner];
                  id_r   <= winner;
                  rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
               end
            end
            CALC: begin
               resp_sum   <= add_sum;
               resp_cout  <= add_cout;
               resp_id    <= id_r;
               resp_valid <= 1'b1;
            end
            RESP: begin
               // Result fields keep their last value after the handshake.
               if (resp_ready) resp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized
// traffic compared against a round-robin/arithmetic reference model.
module tb_adder_arbiter;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int IW = 2;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N-1:0]    req_cin;
   logic            resp_valid;
   logic            resp_ready;
   logic [IW-1:0]   resp_id;
   logic [W-1:0]    resp_sum;
   logic            resp_cout;
   logic            busy;

   int vectors     = 0;
   int miscompares = 0;
   int mdl_ptr     = 0;

   adder_arbiter #(
      .NUM_REQ (N),
      .WIDTH   (W),
      .ID_W    (IW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cin    (req_cin),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   // Reference arbitration: first valid requester from ptr upward, wrapping.
   function automatic int model_pick(logic [N-1:0] v, int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_cin[i]      = c;
   endtask

   task automatic wait_grant(output int g, output int waited, output bit ok);
      ok     = 1'b0;
      g      = -1;
      waited = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (req_ready != '0) begin
            ok     = 1'b1;
            waited = cyc;
            for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
            return;
         end
         step();
      end
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: req_ready=%b after 20 cycles, required a grant", req_ready);
   endtask

   // One full request/response transaction with `hold` cycles of backpressure.
   task automatic run_txn(input bit keep, input int hold, input string tag,
                          output int g, output int waited);
      int           exp_g;
      logic [N-1:0] exp_mask;
      logic [W:0]   exp;
      bit           ok;
      resp_ready = (hold == 0);
      wait_grant(g, waited, ok);
      if (!ok) return;
      exp_g    = model_pick(req_valid, mdl_ptr);
      exp_mask = (exp_g < 0) ? '0 : (N'(1) << exp_g);
      vectors++;
      if (req_ready !== exp_mask) begin
         miscompares++;
         $display("FAIL %s_grant: req_ready=%b required %b", tag, req_ready, exp_mask);
      end
      if (exp_g < 0) exp_g = 0;
      exp = {1'b0, req_a[exp_g*W +: W]} + {1'b0, req_b[exp_g*W +: W]} + (W+1)'(req_cin[exp_g]);
      step();
      mdl_ptr = (exp_g + 1) % N;
      if (!keep) req_valid[exp_g] = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
         miscompares++;
         $display("FAIL %s_calc: resp_valid=%b busy=%b req_ready=%b required 0 1 0",
                  tag, resp_valid, busy, req_ready);
      end
      step();
      vectors++;
      if (resp_valid !== 1'b1 || resp_sum !== exp[W-1:0] || resp_cout !== exp[W] ||
          resp_id !== IW'(exp_g)) begin
         miscompares++;
         $display("FAIL %s_result: valid=%b sum=%h cout=%b id=%0d required 1 %h %b %0d",
                  tag, resp_valid, resp_sum, resp_cout, resp_id, exp[W-1:0], exp[W], exp_g);
      end
      for (int h = 0; h < hold; h++) begin
         step();
         vectors++;
         if (resp_valid !== 1'b1 || resp_sum !== exp[W-1:0] || resp_id !== IW'(exp_g) ||
             req_ready !== '0) begin
            miscompares++;
            $display("FAIL %s_hold: valid=%b sum=%h id=%0d req_ready=%b required 1 %h %0d 0",
                     tag, resp_valid, resp_sum, resp_id, req_ready, exp[W-1:0], exp_g);
         end
      end
      resp_ready = 1'b1;
      step();
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_sum !== exp[W-1:0] ||
          resp_id !== IW'(exp_g)) begin
         miscompares++;
         $display("FAIL %s_release: valid=%b busy=%b sum=%h id=%0d required 0 0 %h %0d",
                  tag, resp_valid, busy, resp_sum, resp_id, exp[W-1:0], exp_g);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_cin    = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_valid: %b required 0", resp_valid);
      end
      vectors++;
      if (resp_sum !== '0 || resp_cout !== 1'b0 || resp_id !== '0) begin
         miscompares++;
         $display("FAIL reset_resp: sum=%h cout=%b id=%0d required 0 0 0", resp_sum, resp_cout, resp_id);
      end
      vectors++;
      if (busy !== 1'b0 || req_ready !== '0) begin
         miscompares++; $display("FAIL reset_idle: busy=%b req_ready=%b required 0 0", busy, req_ready);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      mdl_ptr = 0;
      step();
   endtask

   task automatic test_all_valid();
      int order[5] = '{0, 1, 2, 3, 0};
      int g, w;
      for (int i = 0; i < N; i++) set_req(i, W'(i), W'(10 * i), 1'b1);
      req_valid = '1;
      for (int n = 0; n < 5; n++) begin
         run_txn(1'b1, 0, "all_valid", g, w);
         vectors++;
         if (g != order[n]) begin
            miscompares++; $display("FAIL all_valid_order: grant=%0d required %0d", g, order[n]);
         end
         if (n > 0) begin
            vectors++;
            if (w != 0) begin
               miscompares++; $display("FAIL throughput: idle cycles=%0d required 0", w);
            end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_single();
      int g, w;
      set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      req_valid = 4'b0100;
      run_txn(1'b0, 0, "single", g, w);
   endtask

   task automatic test_wrap();
      int g, w;
      set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      set_req(3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      req_valid = 4'b1010;
      run_txn(1'b0, 0, "wrap_first", g, w);
      vectors++;
      if (g != 3) begin
         miscompares++; $display("FAIL wrap_first: grant=%0d required 3", g);
      end
      run_txn(1'b0, 0, "wrap_second", g, w);
      vectors++;
      if (g != 1) begin
         miscompares++; $display("FAIL wrap_second: grant=%0d required 1", g);
      end
      // rr_ptr should now be 2: with everyone valid, requester 2 wins.
      for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      req_valid = '1;
      run_txn(1'b0, 0, "ptr_probe", g, w);
      vectors++;
      if (g != 2) begin
         miscompares++; $display("FAIL ptr_probe: grant=%0d required 2", g);
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      int g, w;
      set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      req_valid = 4'b0011;
      run_txn(1'b0, 5, "backpressure", g, w);
      run_txn(1'b0, 0, "bp_drain", g, w);
   endtask

   task automatic test_carry_in();
      int g, w;
      set_req(3, '0, '0, 1'b1);
      req_valid = 4'b1000;
      run_txn(1'b0, 0, "carry_in", g, w);
      vectors++;
      if (resp_sum !== 64'd1 || resp_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL carry_in_value: sum=%h cout=%b required 1 0", resp_sum, resp_cout);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] nw;
      int g, w;
      for (int t = 0; t < 40; t++) begin
         nw = N'($urandom_range(0, 15)) & ~req_valid;
         if ((req_valid | nw) == '0) nw = N'(1) << $urandom_range(0, N - 1);
         for (int i = 0; i < N; i++) begin
            if (nw[i]) begin
               if ($urandom_range(0, 3) == 0)
                  set_req(i, '1, {$urandom, $urandom}, 1'($urandom));
               else
                  set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            end
         end
         req_valid = req_valid | nw;
         run_txn(1'b0, $urandom_range(0, 3), "random", g, w);
      end
      for (int d = 0; d < N && req_valid != '0; d++) run_txn(1'b0, 0, "rand_drain", g, w);
   endtask

   task automatic test_reset_mid();
      int g, w;
      bit ok;
      set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      req_valid  = 4'b0001;
      resp_ready = 1'b1;
      wait_grant(g, w, ok);
      step();
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: valid=%b busy=%b req_ready=%b required 0 0 0",
                  resp_valid, busy, req_ready);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      mdl_ptr = 0;
      step();
      for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      req_valid = '1;
      run_txn(1'b0, 0, "post_reset_probe", g, w);
      vectors++;
      if (g != 0) begin
         miscompares++; $display("FAIL post_reset_ptr: grant=%0d required 0", g);
      end
      req_valid = '0;
      set_req(1, 64'd5, 64'd7, 1'b0);
      req_valid = 4'b0010;
      run_txn(1'b0, 0, "post_reset", g, w);
      vectors++;
      if (resp_sum !== 64'd12 || resp_id !== 2'd1) begin
         miscompares++;
         $display("FAIL post_reset_value: sum=%0d id=%0d required 12 1", resp_sum, resp_id);
      end
   endtask

   initial begin
      test_reset();
      test_all_valid();
      test_single();
      test_wrap();
      test_backpressure();
      test_carry_in();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
